fetch_queue: RTL and testbench

Dual-issue instruction buffer between instruction memory and the decoder. Accepts a pair of 32-bit instruction words plus their fetch PC from `imem` each cycle and presents up to two queued instructions, with their PCs, to `dec`. Decouples fetch from decode stalls and drops all buffered instructions on a branch redirect from the ALU.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between imem and the decoder: pairs in, up to two out, flushed on redirect.
// Define FQ_BYPASS_EN to forward an incoming pair straight to the slot outputs when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr0,
  input  logic [31:0]              in_instr1,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid0,
  output logic                     out_valid1,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_pc1,
  input  logic [1:0]               out_take,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a pair transfers on a cycle where in_valid && in_ready; in_ready depends only on registered count.
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_p1, tail_p1;
  logic [31:0]   pc_plus4;
  logic [1:0]    take_req, take_eff, pop_n, wr_n;
  logic [31:0]   wr_instr0, wr_pc0;
  logic          byp;

  always_comb begin
    pc_plus4 = in_pc + 32'd4;
    head_p1  = head_q + AW'(1);
    tail_p1  = tail_q + AW'(1);
    take_req = (out_take == 2'd3) ? 2'd2 : out_take;
    in_ready = (count_q <= CW'(DEPTH - 2));

    byp = 1'b0;
`ifdef FQ_BYPASS_EN
    byp = rst && (count_q == '0) && in_valid && !flush;
`endif

    // When bypassing, the incoming pair counts as the two available entries.
    if (byp || count_q >= CW'(2))        take_eff = take_req;
    else if (CW'(take_req) > count_q)    take_eff = count_q[1:0];
    else                                 take_eff = take_req;

    wr_instr0 = in_instr0;
    wr_pc0    = in_pc;
    if (byp) begin
      pop_n = 2'd0;
      case (take_eff)
        2'd0:    wr_n = 2'd2;
        2'd1: begin
          wr_n      = 2'd1;
          wr_instr0 = in_instr1;
          wr_pc0    = pc_plus4;
        end
        default: wr_n = 2'd0;
      endcase
    end else begin
      pop_n = take_eff;
      wr_n  = (in_valid && in_ready) ? 2'd2 : 2'd0;
    end

    instr_d = instr_q;
    pc_d    = pc_q;
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(wr_n);
    count_d = count_q + CW'(wr_n) - CW'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_n != 2'd0) begin
        instr_d[tail_q] = wr_instr0;
        pc_d[tail_q]    = wr_pc0;
      end
      if (wr_n == 2'd2) begin
        instr_d[tail_p1] = in_instr1;
        pc_d[tail_p1]    = pc_plus4;
      end
    end
  end

  always_comb begin
    out_valid0 = (count_q != '0);
    out_valid1 = (count_q >= CW'(2));
    out_instr0 = instr_q[head_q];
    out_pc0    = pc_q[head_q];
    out_instr1 = instr_q[head_p1];
    out_pc1    = pc_q[head_p1];
    if (byp) begin
      out_valid0 = 1'b1;
      out_valid1 = 1'b1;
      out_instr0 = in_instr0;
      out_pc0    = in_pc;
      out_instr1 = in_instr1;
      out_pc1    = pc_plus4;
    end
    count = count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the buffer contents.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instr0 = '0, in_instr1 = '0, in_pc = '0;
  logic [1:0]    out_take = '0;
  logic          in_ready, out_valid0, out_valid1;
  logic [31:0]   out_instr0, out_instr1, out_pc0, out_pc1;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_take(out_take), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: queued entries oldest first, each {instr, pc}
  logic [63:0] exp_q[$];
  bit          zero_expect = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare mid-cycle, then advance the model with the inputs the next edge will see
  always @(negedge clk) begin : cmp
    int          cnt;
    int          te;
    bit          byp;
    logic [1:0]  take;
    if (!rst) begin
      exp_q.delete();
      zero_expect = 1'b1;
    end
    cnt = exp_q.size();
    byp = BYP && rst && cnt == 0 && in_valid && !flush;
    chk("count", 32'(count), 32'(cnt));
    chk("in_ready", 32'(in_ready), 32'((DEPTH - cnt) >= 2));
    chk("valid0", 32'(out_valid0), 32'(byp || cnt >= 1));
    chk("valid1", 32'(out_valid1), 32'(byp || cnt >= 2));
    if (byp) begin
      chk("byp_instr0", out_instr0, in_instr0);
      chk("byp_pc0", out_pc0, in_pc);
      chk("byp_instr1", out_instr1, in_instr1);
      chk("byp_pc1", out_pc1, in_pc + 32'd4);
    end else begin
      if (cnt >= 1) begin
        chk("instr0", out_instr0, exp_q[0][63:32]);
        chk("pc0", out_pc0, exp_q[0][31:0]);
      end else if (zero_expect) begin
        chk("zero_instr0", out_instr0, 32'd0);
        chk("zero_pc0", out_pc0, 32'd0);
        chk("zero_instr1", out_instr1, 32'd0);
        chk("zero_pc1", out_pc1, 32'd0);
      end
      if (cnt >= 2) begin
        chk("instr1", out_instr1, exp_q[1][63:32]);
        chk("pc1", out_pc1, exp_q[1][31:0]);
      end
    end
    if (rst) begin
      take = (out_take == 2'd3) ? 2'd2 : out_take;
      if (flush) begin
        exp_q.delete();
      end else if (byp) begin
        if (take == 2'd0) begin
          exp_q.push_back({in_instr0, in_pc});
          exp_q.push_back({in_instr1, in_pc + 32'd4});
        end else if (take == 2'd1) begin
          exp_q.push_back({in_instr1, in_pc + 32'd4});
        end
        zero_expect = 1'b0;
      end else begin
        te = (int'(take) > cnt) ? cnt : int'(take);
        repeat (te) void'(exp_q.pop_front());
        if (in_valid && (DEPTH - cnt) >= 2) begin
          exp_q.push_back({in_instr0, in_pc});
          exp_q.push_back({in_instr1, in_pc + 32'd4});
          zero_expect = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input logic [1:0] t, input logic f);
    in_valid  = v;
    in_instr0 = i0;
    in_instr1 = i1;
    in_pc     = pc;
    out_take  = t;
    flush     = f;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_take = 2'd0;
    flush    = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    idle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_pc0", out_pc0, 32'd0);

    // single pair
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h100, 2'd0, 1'b0);
    tick(); idle();
    chk("push_instr0", out_instr0, 32'h1111_1111);
    chk("push_pc0", out_pc0, 32'h100);
    chk("push_instr1", out_instr1, 32'h2222_2222);
    chk("push_pc1", out_pc1, 32'h104);
    chk("push_count", 32'(count), 32'd2);

    // fill to DEPTH, then one take while fetch keeps offering
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 32'hA000_0000 + k, 32'hB000_0000 + k, 32'h100 + 8 * k, 2'd0, 1'b0);
      tick();
    end
    idle();
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'h300, 2'd1, 1'b0);
    tick(); idle();
    chk("take1_count", 32'(count), 32'd7);
    chk("take1_ready", 32'(in_ready), 32'd0);
    chk("take1_instr0", out_instr0, 32'h2222_2222);
    chk("take1_pc0", out_pc0, 32'h104);
    chk("take1_pc1", out_pc1, 32'h108);

    // drain with take=3, including the underflow case
    repeat (3) begin
      out_take = 2'd3;
      tick();
    end
    idle();
    chk("drain_count", 32'(count), 32'd1);
    chk("drain_pc0", out_pc0, 32'h11C);
    chk("drain_instr0", out_instr0, 32'hB000_0003);
    out_take = 2'd3;
    tick(); idle();
    chk("under_count", 32'(count), 32'd0);
    chk("under_valid0", 32'(out_valid0), 32'd0);
    chk("under_ready", 32'(in_ready), 32'd1);

    // sustained push + take 2 across wrap
    drive(1'b1, $urandom, $urandom, 32'h1000, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, $urandom, 32'h1008 + 8 * i, 2'd2, 1'b0);
      tick();
      #1;
      chk("sus_count", 32'(count), 32'd2);
      chk("sus_pc0", out_pc0, 32'h1008 + 8 * i);
    end
    idle();
    out_take = 2'd2;
    tick(); idle();
    chk("sus_empty", 32'(count), 32'd0);

    // flush with a pair offered in the same cycle
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h7000_0000 + k, 32'h7100_0000 + k, 32'h2000 + 8 * k, 2'd0, 1'b0);
      tick();
    end
    idle();
    chk("pre_flush_count", 32'(count), 32'd6);
    drive(1'b1, 32'hDEAD_BEEF, 32'hFEED_FACE, 32'hDEAD_0000, 2'd0, 1'b1);
    tick(); idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid0", 32'(out_valid0), 32'd0);
    chk("flush_valid1", 32'(out_valid1), 32'd0);
    tick();
    chk("flush_stays_empty", 32'(count), 32'd0);
    drive(1'b1, 32'h3333_3333, 32'h4444_4444, 32'h3000, 2'd0, 1'b0);
    tick(); idle();
    chk("post_flush_pc0", out_pc0, 32'h3000);
    chk("post_flush_instr0", out_instr0, 32'h3333_3333);
    out_take = 2'd2;
    tick(); idle();

`ifdef FQ_BYPASS_EN
    drive(1'b1, 32'h5555_5555, 32'h6666_6666, 32'h200, 2'd1, 1'b0);
    #1;
    chk("byp_now_valid0", 32'(out_valid0), 32'd1);
    chk("byp_now_pc0", out_pc0, 32'h200);
    tick(); idle();
    chk("byp_next_pc0", out_pc0, 32'h204);
    chk("byp_next_count", 32'(count), 32'd1);
    out_take = 2'd1;
    tick(); idle();
`endif

    // asynchronous reset mid-cycle with four entries queued
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h9000_0000 + k, 32'h9100_0000 + k, 32'h4000 + 8 * k, 2'd0, 1'b0);
      tick();
    end
    idle();
    chk("pre_rst_count", 32'(count), 32'd4);
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid0", 32'(out_valid0), 32'd0);
    chk("arst_valid1", 32'(out_valid1), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_instr0", out_instr0, 32'd0);
    chk("arst_pc1", out_pc1, 32'd0);
    tick();
    rst = 1'b1;
    tick(); idle();
    chk("after_rst_pc0", out_pc0, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            ((i / 200) % 2 == 1) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1;
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
